// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory controller (slave).
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data RAM controller: valid/ready requests, funct3 load extension,
// store lane shifting, configurable read latency and post-reset RAM zeroing.
//
// state | meaning
// INIT  | zeroing one RAM word per cycle, requests blocked
// READY | RAM initialised, one request accepted per cycle until reset
module data_memory_ctrl #(
  parameter int DEPTH_BYTES  = 1024,
  parameter int ADDR_W       = $clog2(DEPTH_BYTES),
  parameter int READ_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  data_memory_ctrl_if.slave              bus,
  output logic                           init_done,
  output logic [DEPTH_BYTES/4-1:0][31:0] ram_debug
);
  localparam int WORDS  = DEPTH_BYTES / 4;
  localparam int WORD_W = ADDR_W - 2;

  typedef enum logic {INIT, READY} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] cnt, cnt_nxt;
  logic              init_we;
  logic [31:0]       mem [WORDS];

  logic              accept;
  logic              aligned;
  logic              legal;
  logic [WORD_W-1:0] word_idx;
  logic [31:0]       word_rd;
  logic [31:0]       shifted;
  logic [31:0]       load_data;
  logic [31:0]       rsp_data_c;
  logic [31:0]       st_data;
  logic [3:0]        st_be;
  logic              st_we;

  logic [READ_LATENCY-1:0] pv;
  logic [READ_LATENCY-1:0] pe;
  logic [31:0]             pd [READ_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    init_we       = 1'b0;
    init_done     = 1'b0;
    bus.req_ready = 1'b0;
    case (state)
      INIT: begin
        init_we = 1'b1;
        cnt_nxt = cnt + WORD_W'(1);
        if (cnt == WORD_W'(WORDS - 1)) state_nxt = READY;
      end
      READY: begin
        init_done     = 1'b1;
        bus.req_ready = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign accept   = bus.req_valid & bus.req_ready;
  assign word_idx = bus.req_addr[ADDR_W-1:2];

  always_comb begin
    aligned = 1'b1;
    case (bus.req_func3[1:0])
      2'b01:   aligned = ~bus.req_addr[0];
      2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    legal = 1'b0;
    if (bus.req_write)
      legal = aligned & ~bus.req_func3[2] & (bus.req_func3[1:0] != 2'b11);
    else
      legal = aligned & (bus.req_func3[1:0] != 2'b11) & (bus.req_func3 != 3'b110);
  end

  // Load word is read before any same-edge RAM write lands
  assign word_rd = mem[word_idx];
  assign shifted = word_rd >> {bus.req_addr[1:0], 3'b000};

  always_comb begin
    load_data = '0;
    case (bus.req_func3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = word_rd;
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  assign rsp_data_c = (legal & ~bus.req_write) ? load_data : '0;

  assign st_we   = accept & bus.req_write & legal;
  assign st_data = bus.req_wdata << {bus.req_addr[1:0], 3'b000};

  always_comb begin
    st_be = 4'b1111;
    case (bus.req_func3[1:0])
      2'b00:   st_be = 4'b0001 << bus.req_addr[1:0];
      2'b01:   st_be = 4'b0011 << bus.req_addr[1:0];
      default: st_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[cnt] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++)
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  // Each stage only loads when its upstream stage is valid, so the last stage holds between responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv <= '0;
      pe <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pd[k] <= '0;
    end else begin
      pv[0] <= accept;
      if (accept) begin
        pd[0] <= rsp_data_c;
        pe[0] <= ~legal;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) begin
          pd[k] <= pd[k-1];
          pe[k] <= pe[k-1];
        end
      end
    end
  end

  assign bus.rsp_valid = pv[READ_LATENCY-1];
  assign bus.rsp_rdata = pd[READ_LATENCY-1];
  assign bus.rsp_error = pe[READ_LATENCY-1];

  always_comb begin
    for (int i = 0; i < WORDS; i++) ram_debug[i] = mem[i];
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: three instances cover init, access widths/errors,
// pipelined latency, store-then-load ordering and reset in flight.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic done_a, done_b, done_c;
  logic [15:0][31:0] dbg_a;
  logic [31:0][31:0] dbg_b, dbg_c;

  data_memory_ctrl_if #(.ADDR_W(6)) if_a ();
  data_memory_ctrl_if #(.ADDR_W(7)) if_b ();
  data_memory_ctrl_if #(.ADDR_W(7)) if_c ();

  data_memory_ctrl #(.DEPTH_BYTES(64), .READ_LATENCY(1)) u_a (
    .clk(clk), .reset_n(rst_a), .bus(if_a.slave), .init_done(done_a), .ram_debug(dbg_a));
  data_memory_ctrl #(.DEPTH_BYTES(128), .READ_LATENCY(3)) u_b (
    .clk(clk), .reset_n(rst_b), .bus(if_b.slave), .init_done(done_b), .ram_debug(dbg_b));
  data_memory_ctrl #(.DEPTH_BYTES(128), .READ_LATENCY(4)) u_c (
    .clk(clk), .reset_n(rst_c), .bus(if_c.slave), .init_done(done_c), .ram_debug(dbg_c));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic req_a(input logic v, input logic wr, input logic [2:0] f3, input logic [5:0] addr, input logic [31:0] wd);
    if_a.req_valid = v; if_a.req_write = wr; if_a.req_func3 = f3; if_a.req_addr = addr; if_a.req_wdata = wd;
  endtask

  task automatic req_b(input logic v, input logic wr, input logic [2:0] f3, input logic [6:0] addr, input logic [31:0] wd);
    if_b.req_valid = v; if_b.req_write = wr; if_b.req_func3 = f3; if_b.req_addr = addr; if_b.req_wdata = wd;
  endtask

  task automatic req_c(input logic v, input logic wr, input logic [2:0] f3, input logic [6:0] addr, input logic [31:0] wd);
    if_c.req_valid = v; if_c.req_write = wr; if_c.req_func3 = f3; if_c.req_addr = addr; if_c.req_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  logic [31:0] wb [5];

  initial begin
    int cnt;
    int nz;
    int nresp;
    logic seen;

    vecs[0]  = '{1'b1, 3'b010, 6'h10, 32'h8badf00d, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 3'b000, 6'h11, 32'h000000a5, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 3'b001, 6'h16, 32'h00001234, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 6'h11, 32'h0,        32'hffffffa5, 1'b0};
    vecs[4]  = '{1'b0, 3'b100, 6'h11, 32'h0,        32'h000000a5, 1'b0};
    vecs[5]  = '{1'b0, 3'b001, 6'h16, 32'h0,        32'h00001234, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 6'h10, 32'h0,        32'h8bada50d, 1'b0};
    vecs[7]  = '{1'b1, 3'b010, 6'h20, 32'h11223344, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 3'b010, 6'h21, 32'hdeadbeef, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b0, 3'b001, 6'h03, 32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 3'b011, 6'h00, 32'h0,        32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 3'b010, 6'h20, 32'h0,        32'h11223344, 1'b0};
    vecs[12] = '{1'b1, 3'b100, 6'h20, 32'h000000ff, 32'h00000000, 1'b1};
    vecs[13] = '{1'b0, 3'b010, 6'h20, 32'h0,        32'h11223344, 1'b0};
    vecs[14] = '{1'b0, 3'b101, 6'h12, 32'h0,        32'h00008bad, 1'b0};
    vecs[15] = '{1'b0, 3'b001, 6'h12, 32'h0,        32'hffff8bad, 1'b0};
    vecs[16] = '{1'b0, 3'b000, 6'h13, 32'h0,        32'hffffff8b, 1'b0};
    vecs[17] = '{1'b0, 3'b100, 6'h10, 32'h0,        32'h0000000d, 1'b0};

    wb[0] = 32'h01234567; wb[1] = 32'h89abcdef; wb[2] = 32'hdeadbeef;
    wb[3] = 32'h00c0ffee; wb[4] = 32'h76543210;

    req_a(0, 0, 0, 0, 0);
    req_b(0, 0, 0, 0, 0);
    req_c(0, 0, 0, 0, 0);

    // ---------------- instance A: reset state, init, width/error vectors
    tick();
    chk("rst_ready", {31'h0, if_a.req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, if_a.rsp_valid}, 32'h0);
    chk("rst_rdata", if_a.rsp_rdata, 32'h0);
    chk("rst_error", {31'h0, if_a.rsp_error}, 32'h0);
    chk("rst_init_done", {31'h0, done_a}, 32'h0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    cnt = 0;
    while (!if_a.req_ready && cnt < 200) begin
      if (done_a) begin
        failures++; checks++;
        $display("FAIL init_done_early actual=1 required=0");
      end
      cnt++;
      tick();
    end
    chk("init_cycles_a", cnt, 16);
    chk("init_done_a", {31'h0, done_a}, 32'h1);
    nz = 0;
    for (int i = 0; i < 16; i++) if (dbg_a[i] !== 32'h0) nz++;
    chk("init_zero_words_a", nz, 0);

    for (int i = 0; i < NV; i++) begin
      req_a(1, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      tick();
      req_a(0, 0, 0, 0, 0);
      chk($sformatf("vec%0d_valid", i), {31'h0, if_a.rsp_valid}, 32'h1);
      chk($sformatf("vec%0d_rdata", i), if_a.rsp_rdata, vecs[i].rdata);
      chk($sformatf("vec%0d_error", i), {31'h0, if_a.rsp_error}, {31'h0, vecs[i].err});
      tick();
      chk($sformatf("vec%0d_pulse", i), {31'h0, if_a.rsp_valid}, 32'h0);
      chk($sformatf("vec%0d_hold", i), if_a.rsp_rdata, vecs[i].rdata);
    end
    chk("ram_debug4", dbg_a[4], 32'h8bada50d);
    chk("ram_debug5", dbg_a[5], 32'h12340000);
    chk("ram_debug8", dbg_a[8], 32'h11223344);

    // ---------------- instance B: READ_LATENCY=3 throughput and store-then-load
    cnt = 0;
    while (!done_b && cnt < 200) begin cnt++; tick(); end
    chk("init_done_b", {31'h0, done_b}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      req_b(1, 1, 3'b010, 7'(4 * k), wb[k]);
      tick();
    end
    req_b(0, 0, 0, 0, 0);
    repeat (5) tick();
    for (int c = 0; c < 10; c++) begin
      if (c < 5) req_b(1, 0, 3'b010, 7'(4 * c), 0);
      else req_b(0, 0, 0, 0, 0);
      tick();
      chk($sformatf("thru_valid_e%0d", c), {31'h0, if_b.rsp_valid}, {31'h0, (c >= 2 && c <= 6)});
      if (c >= 2 && c <= 6) chk($sformatf("thru_data_e%0d", c), if_b.rsp_rdata, wb[c-2]);
    end
    req_b(1, 1, 3'b010, 7'h40, 32'hcafef00d);
    tick();
    req_b(1, 0, 3'b010, 7'h40, 0);
    tick();
    req_b(0, 0, 0, 0, 0);
    nresp = 0;
    for (int c = 0; c < 8; c++) begin
      if (if_b.rsp_valid) begin
        if (nresp == 1) chk("store_then_load", if_b.rsp_rdata, 32'hcafef00d);
        nresp++;
      end
      tick();
    end
    chk("store_then_load_resps", nresp, 2);

    // ---------------- instance C: READ_LATENCY=4 reset with a load in flight
    cnt = 0;
    while (!done_c && cnt < 200) begin cnt++; tick(); end
    chk("init_done_c", {31'h0, done_c}, 32'h1);
    req_c(1, 1, 3'b010, 7'h08, 32'h5a5a5a5a);
    tick();
    req_c(0, 0, 0, 0, 0);
    repeat (6) tick();
    req_c(1, 0, 3'b010, 7'h08, 0);
    tick();
    req_c(0, 0, 0, 0, 0);
    tick();
    chk("midflight_t1_valid", {31'h0, if_c.rsp_valid}, 32'h0);
    tick();
    chk("midflight_t2_valid", {31'h0, if_c.rsp_valid}, 32'h0);
    rst_c = 1'b0;
    #1;
    chk("rst_c_valid", {31'h0, if_c.rsp_valid}, 32'h0);
    chk("rst_c_rdata", if_c.rsp_rdata, 32'h0);
    chk("rst_c_ready", {31'h0, if_c.req_ready}, 32'h0);
    chk("rst_c_init_done", {31'h0, done_c}, 32'h0);
    chk("rst_c_store_kept", dbg_c[2], 32'h5a5a5a5a);
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (if_c.rsp_valid) seen = 1'b1;
    end
    rst_c = 1'b1;
    cnt = 0;
    while (!if_c.req_ready && cnt < 200) begin
      if (if_c.rsp_valid) seen = 1'b1;
      cnt++;
      tick();
    end
    chk("dropped_rsp", {31'h0, seen}, 32'h0);
    chk("init_cycles_c", cnt, 32);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dbg_c[i] !== 32'h0) nz++;
    chk("reinit_zero_words_c", nz, 0);
    req_c(1, 0, 3'b010, 7'h08, 0);
    tick();
    req_c(0, 0, 0, 0, 0);
    cnt = 0;
    while (!if_c.rsp_valid && cnt < 20) begin cnt++; tick(); end
    chk("reinit_load_lat", cnt, 3);
    chk("reinit_load_data", if_c.rsp_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
